// File: rtl/mem_io_pkg.sv
// Shared constants and types for the memory / memory-mapped I/O stage.
// The MEM_IO_SCRUB_EN build option uses scrub_state_e.
package mem_io_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] ADDR_STAT = 16'hFFFD;
    localparam logic [WORD_W-1:0] ADDR_OUT  = 16'hFFFE;
    localparam logic [WORD_W-1:0] ADDR_IN   = 16'hFFFF;

    // Status word layout: non-empty, full, then a 3-bit count field
    localparam int STAT_NEMPTY  = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_CNT_W   = 3;

    typedef enum logic {
        SCRUB = 1'b0,
        IDLE  = 1'b1
    } scrub_state_e;

endpackage

// File: rtl/mem_io_fifo.sv
// Input-port FIFO. Pushes are refused when full and pops are refused when empty.
// Pointers wrap naturally because the depth is a power of two.
module mem_io_fifo
    import mem_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pushOk, popOk;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) wrPtr_d = wrPtr_q + PW'(1);
        if (popOk)  rdPtr_d = rdPtr_q + PW'(1);
        if (pushOk && !popOk)      count_d = count_q + CNT_W'(1);
        else if (popOk && !pushOk) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/mem_io_unit.sv
// Data memory plus memory-mapped output port, status word and input FIFO.
// Defining MEM_IO_SCRUB_EN zeroes the RAM after every reset while Busy_o is high.
module mem_io_unit
    import mem_io_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] Daddress_i,
    input  logic [WORD_W-1:0] Dout_i,
    input  logic              W_i,
    output logic [WORD_W-1:0] DataIn_o,
    input  logic [WORD_W-1:0] InData_i,
    input  logic              InValid_i,
    output logic              InReady_o,
    output logic [WORD_W-1:0] OutPort_o,
    output logic              Busy_o
);

    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_W-1:0] ram [MEM_DEPTH];
    logic [WORD_W-1:0] DataIn_q, DataIn_d, OutPort_q, OutPort_d;
    logic [WORD_W-1:0] readData, statusWord, fifoHead, ramWdata;
    logic [AW-1:0]     ramIdx, ramWaddr, scrubAddr;
    logic [CNT_W-1:0]  fifoCount;
    logic              ramHit, ramWe, fifoFull, fifoEmpty, fifoPop, busy, cpuWrite;

`ifdef MEM_IO_SCRUB_EN
    scrub_state_e  state_q, state_d;
    logic [AW-1:0] scrubCnt_q, scrubCnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCRUB;
            scrubCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            scrubCnt_q <= scrubCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scrubCnt_d = scrubCnt_q;
        if (state_q == SCRUB) begin
            scrubCnt_d = scrubCnt_q + AW'(1);
            if (scrubCnt_q == AW'(MEM_DEPTH - 1)) state_d = IDLE;
        end
    end

    always_comb begin
        busy      = (state_q == SCRUB);
        scrubAddr = scrubCnt_q;
    end
`else
    assign busy      = 1'b0;
    assign scrubAddr = '0;
`endif

    assign ramIdx   = Daddress_i[AW-1:0];
    assign ramHit   = (Daddress_i[WORD_W-1:AW] == '0);
    assign cpuWrite = W_i && !busy;
    assign fifoPop  = cpuWrite && (Daddress_i == ADDR_IN);

    mem_io_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (InValid_i),
        .pop_i  (fifoPop),
        .data_i (InData_i),
        .head_o (fifoHead),
        .count_o(fifoCount),
        .full_o (fifoFull),
        .empty_o(fifoEmpty)
    );

    always_comb begin
        statusWord = '0;
        statusWord[STAT_NEMPTY] = !fifoEmpty;
        statusWord[STAT_FULL]   = fifoFull;
        statusWord[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifoCount);
    end

    // The RAM is read asynchronously and registered into DataIn, so a same-cycle write returns the old word
    always_comb begin
        readData = '0;
        if (ramHit) begin
            readData = ram[ramIdx];
        end else begin
            case (Daddress_i)
                ADDR_STAT: readData = statusWord;
                ADDR_OUT:  readData = OutPort_q;
                ADDR_IN:   readData = fifoHead;
                default:   readData = '0;
            endcase
        end
    end

    always_comb begin
        DataIn_d  = busy ? '0 : readData;
        OutPort_d = OutPort_q;
        if (cpuWrite && Daddress_i == ADDR_OUT) OutPort_d = Dout_i;
        ramWe    = busy || (cpuWrite && ramHit);
        ramWaddr = busy ? scrubAddr : ramIdx;
        ramWdata = busy ? '0 : Dout_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DataIn_q  <= '0;
            OutPort_q <= '0;
        end else begin
            DataIn_q  <= DataIn_d;
            OutPort_q <= OutPort_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ramWe) ram[ramWaddr] <= ramWdata;
    end

    assign DataIn_o  = DataIn_q;
    assign OutPort_o = OutPort_q;
    assign InReady_o = !fifoFull;
    assign Busy_o    = busy;

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed bench for mem_io_unit: reset, RAM, output port, FIFO and status map.
// Expectations switch on MEM_IO_SCRUB_EN to match the scrub build.
module tb_mem_io_unit;

    localparam int MEM_DEPTH  = 256;
    localparam int FIFO_DEPTH = 4;

`ifdef MEM_IO_SCRUB_EN
    localparam int BUSY_CYCLES = MEM_DEPTH;
    localparam logic [15:0] RAM3_AFTER_RESET = 16'h0000;
`else
    localparam int BUSY_CYCLES = 0;
    localparam logic [15:0] RAM3_AFTER_RESET = 16'h7777;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] Daddress, Dout, DataIn, InData, OutPort;
    logic        W, InValid, InReady, Busy;
    int          checkCount = 0;
    int          failCount  = 0;

    mem_io_unit #(.MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Daddress_i(Daddress),
        .Dout_i    (Dout),
        .W_i       (W),
        .DataIn_o  (DataIn),
        .InData_i  (InData),
        .InValid_i (InValid),
        .InReady_o (InReady),
        .OutPort_o (OutPort),
        .Busy_o    (Busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of bus and producer inputs, then lands 1 time unit after the edge
    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data, input logic wr,
                                 input logic [15:0] inWord, input logic inValid);
        Daddress = addr;
        Dout     = data;
        W        = wr;
        InData   = inWord;
        InValid  = inValid;
        @(posedge clk);
        #1;
    endtask

    task automatic waitScrub(input logic [15:0] addr, input logic [15:0] data, input logic wr);
        int n = 0;
        Daddress = addr;
        Dout     = data;
        W        = wr;
        InValid  = 1'b0;
        while (Busy && n < MEM_DEPTH + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("busyCycles", n, BUSY_CYCLES);
        W = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        Daddress = '0; Dout = '0; W = 1'b0; InData = '0; InValid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitScrub(16'h0000, 16'h0000, 1'b0);

        // Traffic that fills the FIFO and loads OutPort and RAM[3] before a mid-run reset
        applyStimulus(16'hFFFE, 16'h5555, 1'b1, 16'h00A1, 1'b1);
        applyStimulus(16'h0003, 16'h7777, 1'b1, 16'h00A2, 1'b1);
        applyStimulus(16'hFFFE, 16'h0000, 1'b0, 16'h00A3, 1'b1);
        checkOutput("preRstData", DataIn, 16'h5555);
        applyStimulus(16'hFFFE, 16'h0000, 1'b0, 16'h00A4, 1'b1);
        checkOutput("preRstReady", InReady, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstDataIn", DataIn, 16'h0000);
        checkOutput("rstOutPort", OutPort, 16'h0000);
        checkOutput("rstInReady", InReady, 1'b1);
        checkOutput("rstBusy", Busy, BUSY_CYCLES != 0);
        InValid = 1'b0; W = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        waitScrub(16'h0003, 16'hDEAD, 1'b1);

        applyStimulus(16'hFFFD, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("rstStatus", DataIn, 16'h0000);
        applyStimulus(16'h0003, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("ram3AfterRst", DataIn, RAM3_AFTER_RESET);
`ifdef MEM_IO_SCRUB_EN
        applyStimulus(16'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("ram5Scrubbed", DataIn, 16'h0000);
`endif

        applyStimulus(16'h0010, 16'h1234, 1'b1, 16'h0000, 1'b0);
        applyStimulus(16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("ramRead", DataIn, 16'h1234);
        applyStimulus(16'h0010, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
        checkOutput("readBeforeWrite", DataIn, 16'h1234);
        applyStimulus(16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("readAfterWrite", DataIn, 16'hBEEF);
        applyStimulus(16'h00FF, 16'h5A5A, 1'b1, 16'h0000, 1'b0);
        applyStimulus(16'h00FF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("ramTopWord", DataIn, 16'h5A5A);
        applyStimulus(16'h0100, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("beyondRam", DataIn, 16'h0000);

        applyStimulus(16'h0000, 16'h0F0F, 1'b1, 16'h0000, 1'b0);
        applyStimulus(16'hFFFE, 16'h00A5, 1'b1, 16'h0000, 1'b0);
        checkOutput("outPortWrite", OutPort, 16'h00A5);
        applyStimulus(16'hFFFE, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("outPortRead", DataIn, 16'h00A5);
        applyStimulus(16'h8000, 16'h1111, 1'b1, 16'h0000, 1'b0);
        checkOutput("unmappedWrOut", OutPort, 16'h00A5);
        applyStimulus(16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("unmappedRead", DataIn, 16'h0000);
        applyStimulus(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("unmappedWrRam", DataIn, 16'h0F0F);

        for (int k = 1; k <= 4; k++) applyStimulus(16'hFFFD, 16'h0000, 1'b0, 16'(k), 1'b1);
        checkOutput("fullReady", InReady, 1'b0);
        applyStimulus(16'hFFFD, 16'h0000, 1'b0, 16'h0005, 1'b1);
        checkOutput("fullStatus", DataIn, 16'h0013);
        checkOutput("heldOff", InReady, 1'b0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("head1", DataIn, 16'h0001);
        applyStimulus(16'hFFFF, 16'hCAFE, 1'b1, 16'h0055, 1'b1);
        checkOutput("readyAfterPop", InReady, 1'b1);
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("head2", DataIn, 16'h0002);
        applyStimulus(16'hFFFD, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("noPushOnFullPop", DataIn, 16'h000D);

        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0009, 1'b1);
        applyStimulus(16'hFFFD, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("pushPopCount", DataIn, 16'h0009);
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("pushPopHead", DataIn, 16'h0004);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("wrappedHead", DataIn, 16'h0009);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0);
        applyStimulus(16'hFFFD, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("emptyPopStatus", DataIn, 16'h0000);
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0);
        checkOutput("emptyHead", DataIn, 16'h0000);
        checkOutput("emptyReady", InReady, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
